ex_issue_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the `alu`. It registers one decoded instruction and resolves operand forwarding and hazard interlock. It then presents `aluc`, `a` and `b` to the ALU through a single-entry valid/ready buffer. The stage selects shift-amount and immediate operands so that the ALU computes `b << a`, `b >> a` and `lui` without extra muxing.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ex_issue_stage_operand_fwd.sv | 45 ++++
 rtl/ex_issue_stage.sv | 143 ++++++++++++++
 tb/tb_ex_issue_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes and default datapath/register-index widths.
package cpu_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_LUI = 4'b0110;

endpackage

// File: rtl/ex_issue_stage_operand_fwd.sv
// Per-source operand resolution: forwards from EX/MEM or MEM/WB and flags an interlock.
// EX_ISSUE_FWD_EN selects forwarding; otherwise any pending writer to a used source stalls.
module operand_fwd #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic [RW-1:0] src_i,
  input  logic          used_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic [RW-1:0] em_rd_i,
  input  logic          em_wreg_i,
  input  logic          em_m2reg_i,
  input  logic [DW-1:0] em_data_i,
  input  logic [RW-1:0] mw_rd_i,
  input  logic          mw_wreg_i,
  input  logic [DW-1:0] mw_data_i,
  output logic [DW-1:0] fwd_o,
  output logic          hazard_o
);

  logic nz, em_hit, mw_hit;

  // r0 is hardwired, so it never aliases a producer
  assign nz     = |src_i;
  assign em_hit = nz && em_wreg_i && (em_rd_i == src_i);
  assign mw_hit = nz && mw_wreg_i && (mw_rd_i == src_i);

`ifdef EX_ISSUE_FWD_EN
  // EX/MEM is newer than MEM/WB; a load in EX/MEM has no data yet
  always_comb begin
    fwd_o = rf_data_i;
    if (em_hit && !em_m2reg_i) fwd_o = em_data_i;
    else if (mw_hit)           fwd_o = mw_data_i;
  end

  assign hazard_o = used_i && em_hit && em_m2reg_i;
`else
  logic unused_fwd;

  assign fwd_o      = rf_data_i;
  assign hazard_o   = used_i && (em_hit || mw_hit);
  assign unused_fwd = ^{em_m2reg_i, em_data_i, mw_data_i};
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue register feeding the ALU through a one-entry valid/ready buffer.
// Optional operand forwarding under EX_ISSUE_FWD_EN; port list identical in both builds.
module ex_issue_stage #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [3:0]    id_aluc,
  input  logic [DW-1:0] id_qa,
  input  logic [DW-1:0] id_qb,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_sa,
  input  logic          id_shift,
  input  logic          id_aluimm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic [RW-1:0] em_rd,
  input  logic          em_wreg,
  input  logic          em_m2reg,
  input  logic [DW-1:0] em_data,
  input  logic [RW-1:0] mw_rd,
  input  logic          mw_wreg,
  input  logic [DW-1:0] mw_data,
  input  logic          ex_flush,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [3:0]    ex_aluc,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_qb,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wreg,
  output logic          ex_m2reg,
  output logic          ex_wmem
);

  // index 0 = rs, index 1 = rt
  logic [1:0][RW-1:0] src;
  logic [1:0][DW-1:0] rf, fv;
  logic [1:0]         used, haz;
  logic               hazard, xfer;

  assign src  = {id_rt, id_rs};
  assign rf   = {id_qb, id_qa};
  assign used = {(!id_aluimm || id_wmem), !id_shift};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    operand_fwd #(.DW(DW), .RW(RW)) u_fwd (
      .src_i      (src[g]),
      .used_i     (used[g]),
      .rf_data_i  (rf[g]),
      .em_rd_i    (em_rd),
      .em_wreg_i  (em_wreg),
      .em_m2reg_i (em_m2reg),
      .em_data_i  (em_data),
      .mw_rd_i    (mw_rd),
      .mw_wreg_i  (mw_wreg),
      .mw_data_i  (mw_data),
      .fwd_o      (fv[g]),
      .hazard_o   (haz[g])
    );
  end

  logic          vld_q, vld_d;
  logic [3:0]    aluc_q, aluc_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, qb_q, qb_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          wreg_q, wreg_d, m2reg_q, m2reg_d, wmem_q, wmem_d;

  assign hazard   = id_valid && (|haz);
  assign id_ready = clrn && (!vld_q || ex_ready) && !hazard && !ex_flush;
  assign xfer     = id_valid && id_ready;

  always_comb begin
    vld_d   = vld_q;
    aluc_d  = aluc_q;
    a_d     = a_q;
    b_d     = b_q;
    qb_d    = qb_q;
    rd_d    = rd_q;
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    wmem_d  = wmem_q;
    // a flush or a consume-without-refill must not leave side-effect controls armed
    if (ex_flush || (!xfer && ex_ready)) begin
      vld_d  = 1'b0;
      wreg_d = 1'b0;
      wmem_d = 1'b0;
    end else if (xfer) begin
      vld_d   = 1'b1;
      aluc_d  = id_aluc;
      a_d     = id_shift ? {{(DW-5){1'b0}}, id_sa} : fv[0];
      b_d     = id_aluimm ? id_imm : fv[1];
      qb_d    = fv[1];
      rd_d    = id_rd;
      wreg_d  = id_wreg;
      m2reg_d = id_m2reg;
      wmem_d  = id_wmem;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      vld_q   <= 1'b0;
      aluc_q  <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      qb_q    <= '0;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      aluc_q  <= aluc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qb_q    <= qb_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      wmem_q  <= wmem_d;
    end
  end

  assign ex_valid = vld_q;
  assign ex_aluc  = aluc_q;
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_qb    = qb_q;
  assign ex_rd    = rd_q;
  assign ex_wreg  = wreg_q;
  assign ex_m2reg = m2reg_q;
  assign ex_wmem  = wmem_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized scoreboard bench for ex_issue_stage; the reference model follows the build's EX_ISSUE_FWD_EN setting.
module tb_ex_issue_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_valid, id_ready;
  logic [3:0]  id_aluc;
  logic [31:0] id_qa, id_qb, id_imm;
  logic [4:0]  id_sa;
  logic        id_shift, id_aluimm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_wreg, id_m2reg, id_wmem;
  logic [4:0]  em_rd, mw_rd;
  logic        em_wreg, em_m2reg, mw_wreg;
  logic [31:0] em_data, mw_data;
  logic        ex_flush, ex_valid, ex_ready;
  logic [3:0]  ex_aluc;
  logic [31:0] ex_a, ex_b, ex_qb;
  logic [4:0]  ex_rd;
  logic        ex_wreg, ex_m2reg, ex_wmem;

  int total = 0;
  int bad   = 0;
  logic [107:0] sb[$];

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluc(id_aluc), .id_qa(id_qa), .id_qb(id_qb), .id_imm(id_imm), .id_sa(id_sa),
    .id_shift(id_shift), .id_aluimm(id_aluimm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .em_rd(em_rd), .em_wreg(em_wreg), .em_m2reg(em_m2reg), .em_data(em_data),
    .mw_rd(mw_rd), .mw_wreg(mw_wreg), .mw_data(mw_data),
    .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluc(ex_aluc), .ex_a(ex_a), .ex_b(ex_b), .ex_qb(ex_qb), .ex_rd(ex_rd),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

`ifdef EX_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Value seen for a source: the newest non-load writer of that register, else the register file.
  function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rfv);
    logic [4:0]  prd[2];
    logic        pwr[2], pld[2];
    logic [31:0] pdat[2];
    prd = '{em_rd, mw_rd}; pwr = '{em_wreg, mw_wreg};
    pld = '{em_m2reg, 1'b0}; pdat = '{em_data, mw_data};
    if (!FWD || s == 0) return rfv;
    for (int p = 0; p < 2; p++)
      if (pwr[p] && prd[p] == s && !pld[p]) return pdat[p];
    return rfv;
  endfunction

  // A used source must wait when a producer owes it a value the stage cannot obtain yet.
  function automatic logic src_stall(input logic [4:0] s, input logic used);
    if (!used || s == 0) return 1'b0;
    if (em_wreg && em_rd == s && (!FWD || em_m2reg)) return 1'b1;
    if (!FWD && mw_wreg && mw_rd == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_ready();
    logic stall;
    stall = id_valid && (src_stall(id_rs, !id_shift) || src_stall(id_rt, !id_aluimm || id_wmem));
    return clrn && (sb.size() == 0 || ex_ready) && !stall && !ex_flush;
  endfunction

  function automatic logic [107:0] model_out();
    logic [31:0] a, b, q;
    q = src_val(id_rt, id_qb);
    a = id_shift ? 32'(id_sa) : src_val(id_rs, id_qa);
    b = id_aluimm ? id_imm : q;
    return {id_aluc, a, b, q, id_rd, id_wreg, id_m2reg, id_wmem};
  endfunction

  // Monitor: the head entry must be presented (and held) until consumed.
  initial forever begin
    @(negedge clk);
    if (ex_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("payload", {ex_aluc, ex_a, ex_b, ex_qb, ex_rd, ex_wreg, ex_m2reg, ex_wmem}, sb[0]);
        if (ex_ready) void'(sb.pop_front());
      end
    end else begin
      chk("idle_expected", sb.size(), 0);
      chk("idle_ctrl", {ex_wreg, ex_wmem}, 2'b00);
    end
  end

  task automatic tick();
    logic r;
    @(negedge clk); #1;
    r = model_ready();
    chk("id_ready", id_ready, r);
    if (!clrn || ex_flush) sb.delete();
    else if (id_valid && r) sb.push_back(model_out());
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    id_valid = 0; id_aluc = ALUC_ADD; id_qa = 0; id_qb = 0; id_imm = 0; id_sa = 0;
    id_shift = 0; id_aluimm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_wreg = 0; id_m2reg = 0; id_wmem = 0;
    em_rd = 0; em_wreg = 0; em_m2reg = 0; em_data = 0;
    mw_rd = 0; mw_wreg = 0; mw_data = 0; ex_flush = 0;
  endtask

  task automatic set_id(input logic [3:0] aluc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] qa, input logic [31:0] qb);
    id_valid = 1; id_aluc = aluc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_qa = qa; id_qb = qb; id_wreg = 1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {ex_valid, ex_aluc, ex_a, ex_b, ex_qb, ex_rd, ex_wreg, ex_m2reg, ex_wmem}, 0);
  endtask

  initial begin
    clr_in(); clrn = 0; ex_ready = 1;
    tick(); tick();
    chk_all_zero("reset_out");
    clrn = 1;

    // producer then dependent consumer
    set_id(ALUC_ADD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2); tick();
    set_id(ALUC_ADD, 5'd3, 5'd0, 5'd4, 32'hDEAD, 32'h0);
    em_rd = 3; em_wreg = 1; em_data = 32'h10; tick();
    clr_in();

    // load-use, then the same source satisfied from MEM/WB
    set_id(ALUC_ADD, 5'd5, 5'd0, 5'd6, 32'h55, 32'h0);
    em_rd = 5; em_wreg = 1; em_m2reg = 1; tick();
    em_wreg = 0; em_m2reg = 0; em_rd = 0;
    mw_rd = 5; mw_wreg = 1; mw_data = 32'h7; tick();
    clr_in();

    // shift and lui operand selection
    set_id(ALUC_SLL, 5'd0, 5'd2, 5'd7, 32'h99, 32'h1); id_shift = 1; id_sa = 5'd4; tick();
    chk("shift_a", ex_a, 32'h4);
    chk("shift_b", ex_b, 32'h1);
    clr_in();
    set_id(ALUC_LUI, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0); id_aluimm = 1; id_imm = 32'h1234; tick();
    chk("lui_b", ex_b, 32'h1234);
    clr_in();

    // interlock on MEM/WB producer, then rs=0 never matches
    set_id(ALUC_OR, 5'd3, 5'd0, 5'd9, 32'hA5A5, 32'h0); mw_rd = 3; mw_wreg = 1; tick();
    mw_rd = 0; id_rs = 0; tick();
    chk("rs0_a", ex_a, 32'hA5A5);
    clr_in();

    // backpressure: three held cycles, then release
    set_id(ALUC_XOR, 5'd1, 5'd2, 5'd10, 32'h11, 32'h22); tick();
    ex_ready = 0; set_id(ALUC_SUB, 5'd1, 5'd2, 5'd11, 32'h33, 32'h44);
    repeat (3) tick();
    ex_ready = 1; tick();
    chk("bp_new_rd", ex_rd, 5'd11);
    clr_in(); tick();

    // flush alongside an offered instruction
    set_id(ALUC_AND, 5'd1, 5'd1, 5'd12, 32'h1, 32'h1); tick();
    ex_flush = 1; set_id(ALUC_AND, 5'd2, 5'd2, 5'd13, 32'h2, 32'h2); id_wmem = 1; tick();
    chk("flush_ctrl", {ex_valid, ex_wreg, ex_wmem}, 3'b000);
    clr_in();

    // reset in the middle of a hold
    set_id(ALUC_ADD, 5'd1, 5'd2, 5'd14, 32'h5, 32'h6); tick();
    ex_ready = 0; clr_in(); clrn = 0; tick();
    chk_all_zero("reset_mid_hold");
    clrn = 1; ex_ready = 1;

    for (int i = 0; i < 3000; i++) begin
      id_valid  = ($urandom_range(0, 9) < 8);
      id_aluc   = 4'($urandom);
      id_qa     = $urandom; id_qb = $urandom; id_imm = $urandom;
      id_sa     = 5'($urandom);
      id_shift  = ($urandom_range(0, 3) == 0);
      id_aluimm = ($urandom_range(0, 2) == 0);
      id_rs     = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd     = 5'($urandom);
      id_wreg   = 1'($urandom); id_m2reg = 1'($urandom); id_wmem = ($urandom_range(0, 3) == 0);
      em_rd     = 5'($urandom_range(0, 3)); em_wreg = 1'($urandom);
      em_m2reg  = ($urandom_range(0, 3) == 0); em_data = $urandom;
      mw_rd     = 5'($urandom_range(0, 3)); mw_wreg = 1'($urandom); mw_data = $urandom;
      ex_flush  = ($urandom_range(0, 19) == 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      clrn      = ($urandom_range(0, 199) != 0);
      tick();
    end
    clr_in(); clrn = 1; ex_ready = 1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
